// File: rtl/bounce_pixel_gen.sv
// bounce_pixel_gen
// Pixel stage behind the VGA timing controller. It draws a solid box on a
// plain background. Once per frame, in vertical blank, the box moves by STEP
// pixels on each axis. The box bounces off the screen edges. RGB, hsync and
// vsync are all registered once, so colour stays aligned with the syncs.
module bounce_pixel_gen #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [11:0] BOX_COLOR = 12'hF80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       valid,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  // All position arithmetic is 11 bits wide, so box + size can never wrap.
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  V_LINE = 10'(V_ACTIVE);

  // Direction bits are {dy, dx}. A bit value of 1 means that axis is decreasing.
  typedef enum logic [1:0] {
    DR = 2'b00,
    DL = 2'b01,
    UR = 2'b10,
    UL = 2'b11
  } dir_t;

  logic [9:0]  box_x_reg, box_y_reg;
  dir_t        dir_reg;
  logic [11:0] rgb_reg, rgb_next;
  logic        hsync_reg, vsync_reg, frame_tick_reg;
  logic [10:0] x_step_next, y_step_next;  // {flip, new_position}
  logic        tick_next;

  // One axis update. It returns {flip, position}. When the step would reach
  // an edge, the position is clamped to that edge. The direction flips on
  // the same tick.
  function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                            input logic dec,
                                            input logic [10:0] limit);
    logic [10:0] pos_w;
    logic [10:0] res;
    pos_w = {1'b0, pos};
    if (!dec) begin
      if (pos_w + STEP_W >= limit) res = {1'b1, limit[9:0]};
      else                         res = {1'b0, 10'(pos_w + STEP_W)};
    end else begin
      if (pos_w <= STEP_W) res = {1'b1, 10'd0};
      else                 res = {1'b0, 10'(pos_w - STEP_W)};
    end
    return res;
  endfunction

  // Colour for the current input pixel, based on the current box position.
  always_comb begin
    logic [10:0] h_w, v_w, x_w, y_w;
    h_w = {1'b0, h_cnt};
    v_w = {1'b0, v_cnt};
    x_w = {1'b0, box_x_reg};
    y_w = {1'b0, box_y_reg};
    rgb_next = 12'h000;
    if (valid) begin
      if (h_w >= x_w && h_w < x_w + BOX_W && v_w >= y_w && v_w < y_w + BOX_W)
        rgb_next = BOX_COLOR;
      else
        rgb_next = BG_COLOR;
    end
    tick_next   = (h_cnt == 10'd0) && (v_cnt == V_LINE);
    x_step_next = axis_step(box_x_reg, dir_reg[0], X_MAX);
    y_step_next = axis_step(box_y_reg, dir_reg[1], Y_MAX);
  end

  // Output pipeline: colour, delayed syncs and the frame tick pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_reg        <= 12'h000;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      rgb_reg        <= rgb_next;
      hsync_reg      <= hsync_in;
      vsync_reg      <= vsync_in;
      frame_tick_reg <= tick_next;
    end
  end

  // Motion FSM. It steps only in the cycle after frame_tick, so the move
  // always happens in vertical blank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      box_x_reg <= 10'd0;
      box_y_reg <= 10'd0;
      dir_reg   <= DR;
    end else if (frame_tick_reg && enable) begin
      box_x_reg <= x_step_next[9:0];
      box_y_reg <= y_step_next[9:0];
      dir_reg   <= dir_t'({dir_reg[1] ^ y_step_next[10], dir_reg[0] ^ x_step_next[10]});
    end
  end

  assign vgaRed     = rgb_reg[11:8];
  assign vgaGreen   = rgb_reg[7:4];
  assign vgaBlue    = rgb_reg[3:0];
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign frame_tick = frame_tick_reg;

endmodule
